// File: rtl/cdu_phase_gen.sv
// Four-phase CDU timing generator: active-low FAZnDR phase drivers, cycle-aligned
// ISS/RR zero drivers, frame strobe and external sync realignment.
module cdu_phase_gen #(
  parameter int DIV   = 4,
  parameter int FRAME = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       sync,
  input  logic       zero_iss_req,
  input  logic       zero_rr_req,
  output logic       FAZ1DR,
  output logic       FAZ2DR,
  output logic       FAZ3DR,
  output logic       FAZ4DR,
  output logic       FAZ2DR_n,
  output logic       ISSZDR,
  output logic       RRZDR,
  output logic [1:0] phase,
  output logic       active,
  output logic       frame_strobe,
  output logic       sync_err
);
  localparam int DW = $clog2(DIV);
  localparam int FW = $clog2(FRAME);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] divcnt_q, divcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [FW-1:0] frmcnt_q, frmcnt_d;
  logic [3:0]    faz_q, faz_d;
  logic          faz2n_q, faz2n_d;
  logic          iss_q, iss_d, rr_q, rr_d;
  logic          active_q, active_d;
  logic          fs_q, fs_d, serr_q, serr_d;
  logic          eoc, div_end;

  assign div_end = (divcnt_q == DW'(DIV - 1));
  assign eoc     = (phase_q == 2'd3) && div_end;

  always_comb begin
    state_d  = state_q;
    divcnt_d = divcnt_q;
    phase_d  = phase_q;
    frmcnt_d = frmcnt_q;
    iss_d    = iss_q;
    rr_d     = rr_q;
    fs_d     = 1'b0;
    serr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_ACTIVE;
          divcnt_d = '0;
          phase_d  = 2'd0;
          frmcnt_d = '0;
          iss_d    = 1'b1;
          rr_d     = 1'b1;
        end
      end
      default: begin
        state_d = run ? S_ACTIVE : S_DRAIN;
        if (sync && !eoc) begin
          // Misaligned sync: restart at phase 1 and treat it like a cycle boundary.
          divcnt_d = '0;
          phase_d  = 2'd0;
          frmcnt_d = '0;
          serr_d   = 1'b1;
          iss_d    = ~zero_iss_req;
          rr_d     = ~zero_rr_req;
        end else if (eoc) begin
          divcnt_d = '0;
          phase_d  = 2'd0;
          if (!run) begin
            state_d  = S_IDLE;
            frmcnt_d = '0;
            iss_d    = 1'b1;
            rr_d     = 1'b1;
          end else begin
            frmcnt_d = (frmcnt_q == FW'(FRAME - 1)) ? '0 : frmcnt_q + 1'b1;
            fs_d     = (frmcnt_q == FW'(FRAME - 1));
            iss_d    = ~zero_iss_req;
            rr_d     = ~zero_rr_req;
          end
        end else if (div_end) begin
          divcnt_d = '0;
          phase_d  = phase_q + 2'd1;
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end
    endcase
    active_d = (state_d != S_IDLE);
    faz_d    = active_d ? ~(4'b0001 << phase_d) : 4'b1111;
    faz2n_d  = ~faz_d[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      divcnt_q <= '0;
      phase_q  <= 2'd0;
      frmcnt_q <= '0;
      faz_q    <= 4'b1111;
      faz2n_q  <= 1'b0;
      iss_q    <= 1'b1;
      rr_q     <= 1'b1;
      active_q <= 1'b0;
      fs_q     <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      divcnt_q <= divcnt_d;
      phase_q  <= phase_d;
      frmcnt_q <= frmcnt_d;
      faz_q    <= faz_d;
      faz2n_q  <= faz2n_d;
      iss_q    <= iss_d;
      rr_q     <= rr_d;
      active_q <= active_d;
      fs_q     <= fs_d;
      serr_q   <= serr_d;
    end
  end

  assign FAZ1DR       = faz_q[0];
  assign FAZ2DR       = faz_q[1];
  assign FAZ3DR       = faz_q[2];
  assign FAZ4DR       = faz_q[3];
  assign FAZ2DR_n     = faz2n_q;
  assign ISSZDR       = iss_q;
  assign RRZDR        = rr_q;
  assign phase        = phase_q;
  assign active       = active_q;
  assign frame_strobe = fs_q;
  assign sync_err     = serr_q;
endmodule

// File: tb/tb_cdu_phase_gen.sv
// Bench for cdu_phase_gen: two instances (DIV=4/FRAME=16 and DIV=2/FRAME=2) share
// stimulus and are checked every cycle against a time-in-cycle behavioural model.
module tb_cdu_phase_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0, run = 1'b0, sync = 1'b0, zi = 1'b0, zr = 1'b0;
  logic a_f1, a_f2, a_f3, a_f4, a_f2n, a_iss, a_rr, a_act, a_fs, a_se;
  logic b_f1, b_f2, b_f3, b_f4, b_f2n, b_iss, b_rr, b_act, b_fs, b_se;
  logic [1:0] a_ph, b_ph;

  always #5 clk = ~clk;

  cdu_phase_gen #(.DIV(4), .FRAME(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .sync(sync), .zero_iss_req(zi), .zero_rr_req(zr),
    .FAZ1DR(a_f1), .FAZ2DR(a_f2), .FAZ3DR(a_f3), .FAZ4DR(a_f4), .FAZ2DR_n(a_f2n),
    .ISSZDR(a_iss), .RRZDR(a_rr), .phase(a_ph), .active(a_act), .frame_strobe(a_fs),
    .sync_err(a_se));

  cdu_phase_gen #(.DIV(2), .FRAME(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .sync(sync), .zero_iss_req(zi), .zero_rr_req(zr),
    .FAZ1DR(b_f1), .FAZ2DR(b_f2), .FAZ3DR(b_f3), .FAZ4DR(b_f4), .FAZ2DR_n(b_f2n),
    .ISSZDR(b_iss), .RRZDR(b_rr), .phase(b_ph), .active(b_act), .frame_strobe(b_fs),
    .sync_err(b_se));

  // Model: on = generating, t = clocks into the current 4-phase cycle, cyc = cycles into frame.
  typedef struct {
    bit on; int t; int cyc; bit iss; bit rr; bit fs; bit serr;
  } m_t;

  m_t ma, mb;
  int total = 0, bad = 0, ec = 0;
  bit chk_en = 1'b0;

  function automatic m_t step(m_t s, int div, int frame, bit rst, bit rn, bit sy, bit qi, bit qr);
    m_t n = s;
    n.fs = 0; n.serr = 0;
    if (!rst) begin
      n.on = 0; n.t = 0; n.cyc = 0; n.iss = 1; n.rr = 1;
    end else if (!s.on) begin
      if (rn) begin n.on = 1; n.t = 0; n.cyc = 0; n.iss = 1; n.rr = 1; end
    end else if (sy && s.t != 4*div-1) begin
      n.t = 0; n.cyc = 0; n.serr = 1; n.iss = !qi; n.rr = !qr;
    end else if (s.t == 4*div-1) begin
      n.t = 0;
      if (!rn) begin
        n.on = 0; n.cyc = 0; n.iss = 1; n.rr = 1;
      end else begin
        n.cyc = (s.cyc + 1) % frame; n.fs = (n.cyc == 0); n.iss = !qi; n.rr = !qr;
      end
    end else n.t = s.t + 1;
    return n;
  endfunction

  function automatic logic [11:0] expv(m_t s, int div);
    logic [3:0] f = 4'hF;
    int p = s.on ? s.t / div : 0;
    if (s.on) f[p] = 1'b0;
    return {f[0], f[1], f[2], f[3], ~f[1], s.iss, s.rr, 2'(p), s.on, s.fs, s.serr};
  endfunction

  wire [11:0] act_a = {a_f1, a_f2, a_f3, a_f4, a_f2n, a_iss, a_rr, a_ph, a_act, a_fs, a_se};
  wire [11:0] act_b = {b_f1, b_f2, b_f3, b_f4, b_f2n, b_iss, b_rr, b_ph, b_act, b_fs, b_se};

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, ec);
    end
  endtask

  always @(posedge clk) begin
    ma = step(ma, 4, 16, rst_n, run, sync, zi, zr);
    mb = step(mb, 2, 2, rst_n, run, sync, zi, zr);
    ec++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_a", act_a, expv(ma, 4));
      chk("model_b", act_b, expv(mb, 2));
    end
  end

  task automatic wait_ta(input int tv);
    bit hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (ma.on && ma.t == tv) hit = 1;
    end
    if (!hit) chk("wait_timeout", 12'd1, 12'd0);
  endtask

  initial begin
    int s, fa, fb;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_a", act_a, 12'hF60);
    chk("reset_b", act_b, 12'hF60);

    // Start: run seen at next edge gives phase 1 immediately after it.
    rst_n = 1'b1; run = 1'b1;
    @(negedge clk);
    s = ec;
    chk("start_a", {10'd0, a_f1, a_act}, 12'b01);
    chk("start_b", {10'd0, b_f1, b_act}, 12'b01);

    // First frame strobes: 16*4*4 and 2*4*2 clocks after start.
    fa = -1; fb = -1;
    for (int i = 0; i < 300 && fa < 0; i++) begin
      if (a_fs && fa < 0) fa = ec - s;
      if (b_fs && fb < 0) fb = ec - s;
      if (fa < 0) @(negedge clk);
    end
    chk("frame_period_a", 12'(fa), 12'd256);
    chk("frame_period_b", 12'(fb), 12'd16);

    // Drain from phase 2 clock 2, then a drain recovered in phase 3.
    wait_ta(5);  run = 1'b0;
    for (int i = 0; i < 40 && a_act; i++) @(negedge clk);
    chk("drained_a", {8'd0, a_f1, a_f2, a_f3, a_f4} | {11'd0, a_act}, 12'h00F);
    run = 1'b1;
    wait_ta(5);  run = 1'b0;
    wait_ta(9);  run = 1'b1;

    // Zero request: pulse that misses EOC, then one held through EOC.
    wait_ta(5);  zi = 1'b1;
    wait_ta(8);  zi = 1'b0;
    wait_ta(0);
    chk("iss_pulse_a", {11'd0, a_iss}, 12'd1);
    zi = 1'b1;
    wait_ta(0);
    chk("iss_held_a", {10'd0, a_iss, a_rr}, 12'b01);
    zi = 1'b0;

    // Misaligned sync in phase 3, then an aligned one at EOC.
    wait_ta(9);  sync = 1'b1;
    @(negedge clk); sync = 1'b0;
    chk("sync_mis_a", {9'd0, a_se, a_ph, a_act}, 12'b1001);
    wait_ta(15); sync = 1'b1;
    @(negedge clk); sync = 1'b0;
    chk("sync_ok_a", {10'd0, a_se, a_fs}, 12'd0);

    // DIV=2: sync on the first clock of phase 1 is not EOC.
    for (int i = 0; i < 20 && !(mb.on && mb.t == 0); i++) @(negedge clk);
    sync = 1'b1;
    @(negedge clk); sync = 1'b0;
    chk("sync_mis_b", {11'd0, b_se}, 12'd1);

    // Reset mid phase 3 with ISSZDR low, then restart with run held.
    zi = 1'b1; wait_ta(0); zi = 1'b0;
    wait_ta(10); rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_a", act_a, 12'hF60);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_a", {10'd0, a_f1, a_act}, 12'b01);

    // Random traffic, model-checked every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      run   = ($urandom_range(99) < 85);
      sync  = ($urandom_range(99) < 3);
      if ($urandom_range(9) == 0) zi = $urandom_range(1);
      if ($urandom_range(9) == 0) zr = $urandom_range(1);
      rst_n = ($urandom_range(999) >= 3);
    end
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0; sync = 1'b0;
    repeat (40) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
